// File: rtl/tetris_pkg.sv
// Shared types, defaults and arithmetic helpers for the line-clear datapath.
package tetris_pkg;

    localparam int COLS_DEF = 10;
    localparam int ROWS_DEF = 20;

    localparam int PTS_1 = 40;
    localparam int PTS_2 = 100;
    localparam int PTS_3 = 300;
    localparam int PTS_4 = 1200;

    typedef enum logic [2:0] {IDLE, SCAN, SCORE, LEVEL, DONE} state_t;

    // Base points for a clear of n lines; anything past four pays the tetris rate.
    function automatic logic [31:0] ptsFor(input logic [31:0] n);
        if (n == 32'd0)      return 32'd0;
        else if (n == 32'd1) return 32'(PTS_1);
        else if (n == 32'd2) return 32'(PTS_2);
        else if (n == 32'd3) return 32'(PTS_3);
        else                 return 32'(PTS_4);
    endfunction

    function automatic logic [63:0] satAdd(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] maxVal);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, maxVal}) ? maxVal : sum[63:0];
    endfunction

endpackage

// File: rtl/line_clear_scorer.sv
// Score/lines/level bookkeeping: one strobe cycle of scoring, then a level-up loop.
module line_clear_scorer import tetris_pkg::*; #(
    parameter int ROWS            = ROWS_DEF,
    parameter int LINES_PER_LEVEL = 10,
    parameter int LVL_W           = 10,
    parameter int SCORE_W         = 24,
    localparam int CW             = $clog2(ROWS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               strobe,
    input  logic [CW-1:0]      cnt,
    output logic               ready,
    output logic [CW-1:0]      lines_cleared,
    output logic [15:0]        total_lines,
    output logic [LVL_W-1:0]   level,
    output logic [SCORE_W-1:0] score
);

    localparam int PRW = $clog2(LINES_PER_LEVEL + ROWS);
    localparam logic [63:0] SCORE_MAX = (64'd1 << SCORE_W) - 64'd1;

    logic [PRW-1:0] progress;
    logic           active;
    logic [63:0]    award;
    logic           canLevel;

    // Multiplier uses the level in effect before this clear's level-ups.
    assign award    = 64'(ptsFor(32'(cnt))) * (64'(level) + 64'd1);
    assign canLevel = progress >= PRW'(LINES_PER_LEVEL);
    assign ready    = active && !canLevel;

    always_ff @(posedge clk) begin
        if (reset) begin
            lines_cleared <= '0;
            total_lines   <= '0;
            level         <= '0;
            score         <= '0;
            progress      <= '0;
            active        <= 1'b0;
        end else if (strobe) begin
            score         <= SCORE_W'(satAdd(64'(score), award, SCORE_MAX));
            total_lines   <= 16'(satAdd(64'(total_lines), 64'(cnt), 64'hFFFF));
            progress      <= progress + PRW'(cnt);
            lines_cleared <= cnt;
            active        <= 1'b1;
        end else if (active) begin
            if (canLevel) begin
                progress <= progress - PRW'(LINES_PER_LEVEL);
                level    <= (&level) ? level : level + 1'b1;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Multi-line clear engine: bottom-up scan with gravity shift, then scoring/level update.
module line_clear_engine import tetris_pkg::*; #(
    parameter int COLS            = COLS_DEF,
    parameter int ROWS            = ROWS_DEF,
    parameter int LINES_PER_LEVEL = 10,
    parameter int LVL_W           = 10,
    parameter int SCORE_W         = 24,
    localparam int CW             = $clog2(ROWS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ROWS-1:0][COLS-1:0] board_in,
    output logic                      busy,
    output logic                      done,
    output logic [ROWS-1:0][COLS-1:0] board_out,
    output logic [CW-1:0]             lines_cleared,
    output logic [15:0]               total_lines,
    output logic [LVL_W-1:0]          level,
    output logic [SCORE_W-1:0]        score
);

    localparam int PW = $clog2(ROWS);

    state_t         state, nextState;
    logic [PW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic           rowFull;
    logic           scorerReady;

    assign rowFull = &board_out[ptr];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SCAN;
            SCAN:    if (!rowFull && ptr == '0) nextState = SCORE;
            SCORE:   nextState = LEVEL;
            LEVEL:   if (scorerReady) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            board_out <= '0;
            ptr       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    board_out <= board_in;
                    ptr       <= PW'(ROWS - 1);
                    cnt       <= '0;
                    busy      <= 1'b1;
                end
                SCAN: begin
                    // A cleared row pulls everything above it down one; ptr stays put
                    // because the row that dropped in may itself be full.
                    if (rowFull) begin
                        for (int r = ROWS - 1; r > 0; r--)
                            if (r <= int'(ptr)) board_out[r] <= board_out[r-1];
                        board_out[0] <= '0;
                        cnt          <= cnt + 1'b1;
                    end else if (ptr != '0) begin
                        ptr <= ptr - 1'b1;
                    end
                end
                LEVEL: if (scorerReady) busy <= 1'b0;
                DONE:  done <= 1'b1;
                default: ;
            endcase
        end
    end

    line_clear_scorer #(
        .ROWS(ROWS), .LINES_PER_LEVEL(LINES_PER_LEVEL), .LVL_W(LVL_W), .SCORE_W(SCORE_W)
    ) uScorer (
        .clk(clk),
        .reset(reset),
        .strobe(state == SCORE),
        .cnt(cnt),
        .ready(scorerReady),
        .lines_cleared(lines_cleared),
        .total_lines(total_lines),
        .level(level),
        .score(score)
    );

endmodule

// File: tb/tb_line_clear_engine.sv
// Table-driven bench with an expected-result queue popped on each done pulse.
module tb_line_clear_engine;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int NV   = 16;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef struct {
        bit     rst;
        board_t bin;
        board_t ebrd;
        int     eLines;
        int     eTotal;
        int     eLevel;
        int     eScore;
        int     eLat;
    } vec_t;

    typedef struct {
        board_t ebrd;
        int     eLines;
        int     eTotal;
        int     eLevel;
        int     eScore;
        int     eLat;
        int     startCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    board_t      board_in = '0;
    logic        busy, done;
    board_t      board_out;
    logic [4:0]  lines_cleared;
    logic [15:0] total_lines;
    logic [9:0]  level;
    logic [23:0] score;

    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatch = 0;
    int   doneCount = 0;
    exp_t sbq[$];
    vec_t vecs[NV];

    line_clear_engine #(
        .COLS(COLS), .ROWS(ROWS), .LINES_PER_LEVEL(10), .LVL_W(10), .SCORE_W(24)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .board_in(board_in),
        .busy(busy), .done(done), .board_out(board_out),
        .lines_cleared(lines_cleared), .total_lines(total_lines),
        .level(level), .score(score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every done pops one expected record.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                doneCount++;
                if (sbq.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL unexpectedDone: done seen with nothing pending (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("board",   256'(board_out),     256'(e.ebrd));
                    chk("lines",   256'(lines_cleared), 256'(e.eLines));
                    chk("total",   256'(total_lines),   256'(e.eTotal));
                    chk("level",   256'(level),         256'(e.eLevel));
                    chk("score",   256'(score),         256'(e.eScore));
                    chk("latency", 256'(cyc - e.startCyc), 256'(e.eLat));
                    chk("busyAtDone", 256'(busy), 256'(0));
                end
            end
        end
    end

    task automatic doReset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstBoard", 256'(board_out), 256'(0));
        chk("rstLines", 256'(lines_cleared), 256'(0));
        chk("rstTotal", 256'(total_lines), 256'(0));
        chk("rstLevel", 256'(level), 256'(0));
        chk("rstScore", 256'(score), 256'(0));
        chk("rstBusy",  256'(busy), 256'(0));
        chk("rstDone",  256'(done), 256'(0));
        reset = 1'b0;
    endtask

    task automatic pulseStart(input board_t b);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic pushExp(input vec_t v, input int startCyc);
        exp_t e;
        e.ebrd = v.ebrd; e.eLines = v.eLines; e.eTotal = v.eTotal;
        e.eLevel = v.eLevel; e.eScore = v.eScore; e.eLat = v.eLat;
        e.startCyc = startCyc;
        sbq.push_back(e);
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 200 && sbq.size() != 0; t++) @(negedge clk);
        if (sbq.size() != 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL doneTimeout: %0d results still pending (cycle %0d)", sbq.size(), cyc);
            sbq.delete();
        end
        @(negedge clk);
        chk("donePulseWidth", 256'(done), 256'(0));
    endtask

    task automatic runVec(input vec_t v);
        @(negedge clk);
        board_in = v.bin;
        start    = 1'b1;
        pushExp(v, cyc + 1);
        @(negedge clk);
        start    = 1'b0;
        waitDrain();
    endtask

    initial begin
        board_t b;
        int     dc0;

        for (int i = 0; i < NV; i++) begin
            vecs[i].rst = 1'b0; vecs[i].bin = '0; vecs[i].ebrd = '0;
        end
        // Single clear with residue falling into the bottom row.
        vecs[0].rst = 1'b1;
        vecs[0].bin[19] = 10'h3FF; vecs[0].bin[18] = 10'h001;
        vecs[0].ebrd[19] = 10'h001;
        vecs[0].eLines = 1; vecs[0].eTotal = 1; vecs[0].eLevel = 0; vecs[0].eScore = 40; vecs[0].eLat = 24;
        // Two non-adjacent full rows.
        vecs[1].bin[19] = 10'h3FF; vecs[1].bin[18] = 10'h0F0;
        vecs[1].bin[17] = 10'h3FF; vecs[1].bin[16] = 10'h00F;
        vecs[1].ebrd[19] = 10'h0F0; vecs[1].ebrd[18] = 10'h00F;
        vecs[1].eLines = 2; vecs[1].eTotal = 3; vecs[1].eLevel = 0; vecs[1].eScore = 140; vecs[1].eLat = 25;
        // Tetris.
        for (int r = 16; r < 20; r++) vecs[2].bin[r] = 10'h3FF;
        vecs[2].bin[15] = 10'h155; vecs[2].ebrd[19] = 10'h155;
        vecs[2].eLines = 4; vecs[2].eTotal = 7; vecs[2].eLevel = 0; vecs[2].eScore = 1340; vecs[2].eLat = 27;
        // Nothing to clear: board and score untouched, done still pulses.
        vecs[3].bin[19] = 10'h155; vecs[3].ebrd[19] = 10'h155;
        vecs[3].eLines = 0; vecs[3].eTotal = 7; vecs[3].eLevel = 0; vecs[3].eScore = 1340; vecs[3].eLat = 23;
        // Whole board full from a fresh reset: two level-ups after scoring at level 0.
        vecs[4].rst = 1'b1;
        for (int r = 0; r < ROWS; r++) vecs[4].bin[r] = 10'h3FF;
        vecs[4].eLines = 20; vecs[4].eTotal = 20; vecs[4].eLevel = 2; vecs[4].eScore = 1200; vecs[4].eLat = 45;
        // Ten single clears cross the first level boundary; the 11th scores at level 1.
        for (int k = 0; k < 11; k++) begin
            vecs[5+k].rst     = (k == 0);
            vecs[5+k].bin[19] = 10'h3FF;
            vecs[5+k].eLines  = 1;
            vecs[5+k].eTotal  = k + 1;
            vecs[5+k].eLevel  = (k >= 9) ? 1 : 0;
            vecs[5+k].eScore  = (k == 10) ? 480 : 40 * (k + 1);
            vecs[5+k].eLat    = (k == 9) ? 25 : 24;
        end

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) doReset();
            runVec(vecs[i]);
        end

        // Start during SCAN must be dropped: one done, result of the first board only.
        doReset();
        dc0 = doneCount;
        b = '0; b[19] = 10'h3FF; b[18] = 10'h001;
        @(negedge clk);
        board_in = b; start = 1'b1;
        pushExp(vecs[0], cyc + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        b = '1;
        pulseStart(b);
        waitDrain();
        repeat (40) @(negedge clk);
        chk("ignoredStartDones", 256'(doneCount - dc0), 256'(1));

        // Reset in the middle of a scan aborts cleanly with no done.
        b = '0; b[19] = 10'h3FF; b[18] = 10'h001;
        pulseStart(b);
        repeat (3) @(negedge clk);
        chk("busyMidScan", 256'(busy), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("abortBoard", 256'(board_out), 256'(0));
        chk("abortScore", 256'(score), 256'(0));
        chk("abortTotal", 256'(total_lines), 256'(0));
        chk("abortBusy",  256'(busy), 256'(0));
        chk("abortDone",  256'(done), 256'(0));
        reset = 1'b0;
        dc0 = doneCount;
        repeat (40) @(negedge clk);
        chk("abortNoDone", 256'(doneCount - dc0), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
